// File: rtl/exe_mdu_ctrl.sv
// exe_mdu_ctrl: iterative multiply/divide sequencer for the EXE stage.
// Runs 32-iteration shift-add multiply or restoring divide, owns HI/LO,
// stalls HI/LO users while busy and feeds MFHI/MFLO data to the EXE mux.
//
// Handshake: estart is taken only when idle and not killed; while busy,
// any EXE HI/LO request (estart/emfhi/emflo/emthi/emtlo) raises stall and
// must be held by the pipeline until stall drops.
module exe_mdu_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             estart,
  input  logic [1:0]       eop,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic             emfhi,
  input  logic             emflo,
  input  logic             emthi,
  input  logic             emtlo,
  input  logic             ekill,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] emdu
);

  typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

  state_t           state;
  logic [4:0]       cnt;
  logic [1:0]       op;
  logic [WIDTH-1:0] acc;     // multiply: upper product; divide: remainder
  logic [WIDTH-1:0] mplr;    // multiply: multiplier/lower product; divide: quotient
  logic [WIDTH-1:0] mcand;   // multiplicand or divisor magnitude
  logic             neg_res;
  logic             neg_rem;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH+1:0] trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign busy  = (state != IDLE);
  assign stall = busy & (estart | emfhi | emflo | emthi | emtlo);
  assign emdu  = emfhi ? hi : lo;

  // Operand magnitudes at accept and per-iteration datapath results
  always_comb begin
    a_neg    = ~eop[0] & ea[WIDTH-1];
    b_neg    = ~eop[0] & eb[WIDTH-1];
    a_mag    = a_neg ? -ea : ea;
    b_mag    = b_neg ? -eb : eb;
    add_sum  = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    trial    = {1'b0, acc, mplr[WIDTH-1]} - {2'b00, mcand};
    prod_fix = neg_res ? -{acc, mplr} : {acc, mplr};
    quo_fix  = neg_res ? -mplr : mplr;
    rem_fix  = neg_rem ? -acc : acc;
  end

  // Sequencer: accept, iterate, sign fix-up and HI/LO writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      op      <= 2'b00;
      acc     <= '0;
      mplr    <= '0;
      mcand   <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!ekill) begin
            if (estart) begin
              op      <= eop;
              cnt     <= 5'd0;
              neg_res <= a_neg ^ b_neg;
              neg_rem <= a_neg;
              if (eop[1] && eb == '0) begin
                // Divide by zero: park the raw dividend for HI and skip ITER
                acc   <= ea;
                mplr  <= '0;
                mcand <= '0;
                state <= FIX;
              end else begin
                acc   <= '0;
                mplr  <= eop[1] ? a_mag : b_mag;
                mcand <= eop[1] ? b_mag : a_mag;
                state <= ITER;
              end
            end else begin
              if (emthi) hi <= ea;
              if (emtlo) lo <= ea;
            end
          end
        end
        ITER: begin
          if (ekill) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 5'd1;
            if (op[1]) begin
              if (!trial[WIDTH+1]) begin
                acc  <= trial[WIDTH-1:0];
                mplr <= {mplr[WIDTH-2:0], 1'b1};
              end else begin
                acc  <= {acc[WIDTH-2:0], mplr[WIDTH-1]};
                mplr <= {mplr[WIDTH-2:0], 1'b0};
              end
            end else begin
              acc  <= add_sum[WIDTH:1];
              mplr <= {add_sum[0], mplr[WIDTH-1:1]};
            end
            if (cnt == 5'd31) state <= FIX;
          end
        end
        FIX: begin
          if (!ekill) begin
            if (op[1]) begin
              if (mcand == '0) begin
                hi <= acc;
                lo <= {WIDTH{1'b1}};
              end else begin
                hi <= rem_fix;
                lo <= quo_fix;
              end
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_mdu_ctrl.sv
// tb_exe_mdu_ctrl: scoreboard bench for the multiply/divide sequencer.
module tb_exe_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        estart = 1'b0;
  logic [1:0]  eop = 2'b00;
  logic [31:0] ea = '0;
  logic [31:0] eb = '0;
  logic        emfhi = 1'b0, emflo = 1'b0, emthi = 1'b0, emtlo = 1'b0;
  logic        ekill = 1'b0;
  logic        busy, stall;
  logic [31:0] hi, lo, emdu;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  exe_mdu_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .estart(estart), .eop(eop), .ea(ea), .eb(eb),
    .emfhi(emfhi), .emflo(emflo), .emthi(emthi), .emtlo(emtlo),
    .ekill(ekill), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .emdu(emdu)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: returns {hi, lo}
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      2'b00: model = sa * sb;
      2'b01: model = ua * ub;
      2'b10: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          model = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else model = {(ua % ub), 32'b0} | (ua / ub);
      end
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // driver: issue one op, wait for completion, compare via scoreboard
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [63:0] e;
    int lat;
    lat = (o[1] && b == 0) ? 1 : 33;
    exp_q.push_back(model(o, a, b));
    estart = 1'b1; eop = o; ea = a; eb = b;
    tick();
    estart = 1'b0;
    check("busy_after_accept", {63'b0, busy}, 64'd1);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check("latency", 64'(n), 64'(lat));
    e = exp_q.pop_front();
    check("result_hilo", {hi, lo}, e);
  endtask

  initial begin
    int n;
    logic [1:0] ro;
    logic [31:0] rb;

    // reset state
    #2;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy_stall", {62'b0, busy, stall}, 64'd0);
    check("rst_emdu", {32'b0, emdu}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // directed ops from the plan
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD);
    check("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
    run_op(2'b11, 32'd100, 32'd7);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});
    run_op(2'b10, 32'd5, 32'd0);
    check("div0_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_op(2'b11, 32'hDEAD_BEEF, 32'd0);

    // ekill in IDLE suppresses accept
    estart = 1'b1; ekill = 1'b1; eop = 2'b01; ea = 32'd9; eb = 32'd9;
    tick();
    estart = 1'b0; ekill = 1'b0;
    check("kill_idle_busy", {63'b0, busy}, 64'd0);

    // MULTU max x max with MFHI held behind the stall
    exp_q.push_back(model(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
    estart = 1'b1; eop = 2'b01; ea = 32'hFFFF_FFFF; eb = 32'hFFFF_FFFF;
    tick();
    estart = 1'b0; emfhi = 1'b1;
    n = 0;
    while (busy && n < 100) begin
      check("mfhi_stall", {63'b0, stall}, 64'd1);
      tick();
      n++;
    end
    check("mfhi_latency", 64'(n), 64'd33);
    check("mfhi_stall_drop", {63'b0, stall}, 64'd0);
    check("mfhi_emdu", {32'b0, emdu}, 64'h0000_0000_FFFF_FFFE);
    emfhi = 1'b0; emflo = 1'b1;
    #1;
    check("mflo_emdu", {32'b0, emdu}, 64'd1);
    check("multu_sb", {hi, lo}, exp_q.pop_front());
    tick();
    emflo = 1'b0;

    // MTHI preload, DIVU killed at cnt==10, then MTLO
    emthi = 1'b1; ea = 32'hAAAA_AAAA;
    tick();
    emthi = 1'b0;
    check("mthi", {32'b0, hi}, 64'h0000_0000_AAAA_AAAA);
    estart = 1'b1; eop = 2'b11; ea = 32'd1000; eb = 32'd3;
    tick();
    estart = 1'b0;
    repeat (10) tick();
    check("busy_before_kill", {63'b0, busy}, 64'd1);
    ekill = 1'b1;
    tick();
    ekill = 1'b0;
    check("kill_busy", {63'b0, busy}, 64'd0);
    check("kill_hi", {32'b0, hi}, 64'h0000_0000_AAAA_AAAA);
    emtlo = 1'b1; ea = 32'h0000_1234;
    tick();
    emtlo = 1'b0;
    check("mtlo", {hi, lo}, {32'hAAAA_AAAA, 32'h0000_1234});

    // reset mid-MULT at cnt==20
    estart = 1'b1; eop = 2'b00; ea = 32'd123; eb = 32'd456;
    tick();
    estart = 1'b0;
    repeat (20) tick();
    rst = 1'b1;
    #1;
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_busy", {62'b0, busy, stall}, 64'd0);
    tick();
    rst = 1'b0;
    run_op(2'b01, 32'd3, 32'd4);
    check("post_rst_multu", {hi, lo}, {32'd0, 32'd12});

    // random ops across all four opcodes
    for (int i = 0; i < 12; i++) begin
      ro = 2'($urandom_range(0, 3));
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(ro, $urandom, rb);
    end

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exe_mdu_ctrl.md
# exe_mdu_ctrl

Iterative multiply/divide sequencer attached to the EXE stage of the pipelined MIPS core. It accepts MULT/MULTU/DIV/DIVU from EXE, runs a 32-iteration shift-add or restoring-divide datapath, and owns the HI/LO registers. While it is busy, it stalls any EXE instruction that touches HI/LO. It supplies MFHI/MFLO data for the EXE result mux alongside the ALU and PC+8 sources.

## Interface
- WIDTH, 32, operand and HI/LO width. Only 32 is supported.

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- estart  in  1  EXE holds a MULT/MULTU/DIV/DIVU
- eop  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- ea  in  32  rs operand (multiplicand / dividend / MTHI/MTLO data)
- eb  in  32  rt operand (multiplier / divisor)
- emfhi, emflo, emthi, emtlo  in  1 each  EXE HI/LO move requests (mutually exclusive with estart)
- ekill  in  1  flush of the EXE instruction (branch/exception)
- busy  out  1  operation in progress
- stall  out  1  freeze IF/ID/EXE this cycle
- hi, lo  out  32  architectural HI/LO
- emdu  out  32  emfhi ? hi : lo (combinational, from registered hi/lo)

## Operation
- States: IDLE, ITER, FIX.
- stall = busy & (estart | emfhi | emflo | emthi | emtlo). Combinational. busy = (state != IDLE).
- An op is accepted in IDLE when estart & !ekill. It latches eop and operand magnitudes (MULT/DIV: two's-complement absolute value; unsigned: raw), latches the result signs, and clears iteration count cnt[4:0].
- ITER, multiply: 64-bit {acc, mplr} shift-add, one multiplier bit per cycle, LSB first.
- ITER, divide: restoring divide on a 64-bit {rem, quo} shift register, one quotient bit per cycle.
- cnt increments every ITER cycle. After cnt==31 the block goes to FIX.
- FIX, multiply: negate the 64-bit product if the operand signs differ (MULT only). Then {hi, lo} <= product.
- FIX, divide: negate the quotient if the operand signs differ, and give the remainder the dividend's sign (DIV only). Then lo <= quotient, hi <= remainder. After FIX the block returns to IDLE.
- -2^31 / -1 (DIV): lo=32'h8000_0000, hi=0. No trap.
- Divide by zero (eb==0 at accept): ITER is skipped, going IDLE -> FIX directly. Result: hi=ea, lo=32'hFFFF_FFFF, for both signed and unsigned.
- emthi/emtlo in IDLE and not ekill: hi/lo <= ea at the next edge. They are ignored (stalled) while busy.
- ekill while in ITER or FIX aborts the op: back to IDLE next edge, hi/lo unchanged. ekill in IDLE suppresses accept and moves.
- A new estart in the cycle FIX completes stalls, because busy is still high. It is accepted the following cycle.

## Timing
- Reset (async, immediate): state=IDLE, cnt=0, hi=0, lo=0, busy=0, stall=0. emdu=0 follows from this.
- Normal op: accept edge at cycle 0, ITER cycles 1-32, FIX cycle 33. hi/lo are valid and busy=0 from cycle 34, for a 34-cycle latency.
- Divide by zero: accept at cycle 0, FIX at cycle 1, result visible at cycle 2.
- MFHI/MFLO issued while busy is stalled. It sees the new value in the first cycle busy=0, with no extra bubble.
- rst asserted mid-op: the op is lost and hi=lo=0. First accept is possible at the first edge after rst deasserts.
- Only one op is in flight. There is no queueing.

## Test plan
- MULT 7 × -3 (eb=32'hFFFF_FFFD) -> busy for cycles 1-33; hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB at cycle 34.
- DIVU 100 / 7 -> lo=14, hi=2. DIV -7 / 2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIV 32'h8000_0000 / -1 -> lo=32'h8000_0000, hi=0.
- DIV 5 / 0 -> hi=5, lo=32'hFFFF_FFFF, busy low at cycle 2.
- MULTU 32'hFFFF_FFFF × 32'hFFFF_FFFF, then back-to-back MFHI:
  - stall=1 from cycle 1 through cycle 33.
  - At cycle 34, emdu=32'hFFFF_FFFE and stall=0.
  - MFLO then gives emdu=1.
- Preload hi=32'hAAAA_AAAA with MTHI, start DIVU, pulse ekill at cnt==10:
  - idle next cycle, hi unchanged.
  - an immediate MTLO 32'h1234 writes lo.
- Assert rst at cnt==20 of a MULT -> outputs zero immediately; after release, MULTU 3 × 4 gives lo=12, hi=0.
